// File: rtl/bit_ram_rmw.sv
// Bit-addressable RAM with atomic set/clear/toggle, aligned word reads and a word-at-a-time clear sweep.
// One-cycle op latency; requests arriving during the sweep are dropped and flagged on err.
module bit_ram_rmw #(
   parameter int DEPTH    = 256,
   parameter int ADDR_LEN = 8,
   parameter int WORD_W   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [2:0]          op,
   input  logic [ADDR_LEN-1:0] addr,
   input  logic                din,
   output logic                dout,
   output logic [WORD_W-1:0]   wdout,
   output logic                valid,
   output logic                busy,
   output logic                err
);

   localparam int WORDS = DEPTH / WORD_W;
   localparam int WBIT  = $clog2(WORD_W);
   localparam int PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   generate
      if (DEPTH != (1 << ADDR_LEN) || WORD_W < 2 || WORD_W > DEPTH ||
          (WORD_W & (WORD_W - 1)) != 0) begin : gBadParams
         $error("bit_ram_rmw: illegal DEPTH/ADDR_LEN/WORD_W combination");
      end
   endgenerate

   typedef enum logic [2:0] {
      OP_NOP    = 3'b000,
      OP_RD     = 3'b001,
      OP_WR     = 3'b010,
      OP_SET    = 3'b011,
      OP_CLR    = 3'b100,
      OP_TGL    = 3'b101,
      OP_RDW    = 3'b110,
      OP_CLRALL = 3'b111
   } opT;

   typedef enum logic {IDLE, SWEEP} stateT;

   stateT               state;
   logic [PTR_W-1:0]    ptr;
   logic [DEPTH-1:0]    mem;
   logic                accept;
   logic                oldBit;
   logic                lastWord;
   logic [ADDR_LEN-1:0] wordBase;
   logic [ADDR_LEN-1:0] sweepBase;

   assign busy      = (state == SWEEP);
   assign accept    = en && (state == IDLE);
   assign oldBit    = mem[addr];
   assign lastWord  = (ptr == PTR_W'(WORDS - 1));
   assign wordBase  = addr & ~ADDR_LEN'(WORD_W - 1);
   assign sweepBase = ADDR_LEN'(ptr) << WBIT;

   // Storage deliberately has no reset; only the sweep clears it.
   always_ff @(posedge clk) begin
      if (state == SWEEP) begin
         mem[sweepBase +: WORD_W] <= '0;
      end else if (accept) begin
         case (op)
            OP_WR:   mem[addr] <= din;
            OP_SET:  mem[addr] <= 1'b1;
            OP_CLR:  mem[addr] <= 1'b0;
            OP_TGL:  mem[addr] <= ~oldBit;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= SWEEP;
         ptr   <= '0;
         dout  <= 1'b0;
         wdout <= '0;
         valid <= 1'b0;
         err   <= 1'b0;
      end else begin
         valid <= 1'b0;
         err   <= en && (state == SWEEP);
         if (state == SWEEP) begin
            ptr <= ptr + 1'b1;
            if (lastWord) begin
               state <= IDLE;
               ptr   <= '0;
            end
         end else if (accept) begin
            case (op)
               OP_RD, OP_SET, OP_CLR, OP_TGL: begin
                  dout  <= oldBit;
                  valid <= 1'b1;
               end
               OP_RDW: begin
                  wdout <= mem[wordBase +: WORD_W];
                  valid <= 1'b1;
               end
               OP_CLRALL: begin
                  state <= SWEEP;
                  ptr   <= '0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bit_ram_rmw.sv
// Directed and randomized checks of bit_ram_rmw against a bit-array reference model.
module tb_bit_ram_rmw;
   logic       clk = 1'b0;
   logic       reset, en, din;
   logic [2:0] op;
   logic [7:0] addr;
   logic       dout, valid, busy, err;
   logic [7:0] wdout;

   always #5 clk = ~clk;

   bit_ram_rmw #(.DEPTH(256), .ADDR_LEN(8), .WORD_W(8)) dut (
      .clk(clk), .reset(reset), .en(en), .op(op), .addr(addr), .din(din),
      .dout(dout), .wdout(wdout), .valid(valid), .busy(busy), .err(err)
   );

   int nVec = 0;
   int nMis = 0;

   logic       refMem [256];
   int         sweepLeft;
   logic       expDout, expValid, expErr;
   logic [7:0] expW;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      check({tag, ".dout"},  32'(dout),  32'(expDout));
      check({tag, ".wdout"}, 32'(wdout), 32'(expW));
      check({tag, ".valid"}, 32'(valid), 32'(expValid));
      check({tag, ".busy"},  32'(busy),  32'(sweepLeft > 0));
      check({tag, ".err"},   32'(err),   32'(expErr));
   endtask

   // One clock edge: drive at the falling edge, model the rising edge, compare 1ns later.
   task automatic step(input logic e, input logic [2:0] o, input logic [7:0] a, input logic d,
                       input string tag);
      int base;
      logic old;
      @(negedge clk);
      en = e; op = o; addr = a; din = d;
      @(posedge clk);
      expErr   = e && (sweepLeft > 0);
      expValid = 1'b0;
      if (sweepLeft > 0) begin
         base = (32 - sweepLeft) * 8;
         for (int i = 0; i < 8; i++) refMem[base + i] = 1'b0;
         sweepLeft--;
      end else if (e) begin
         old = refMem[a];
         case (o)
            3'd1: begin expDout = old; expValid = 1'b1; end
            3'd2: refMem[a] = d;
            3'd3: begin expDout = old; expValid = 1'b1; refMem[a] = 1'b1; end
            3'd4: begin expDout = old; expValid = 1'b1; refMem[a] = 1'b0; end
            3'd5: begin expDout = old; expValid = 1'b1; refMem[a] = ~old; end
            3'd6: begin
               base = a - (a % 8);
               for (int i = 0; i < 8; i++) expW[i] = refMem[base + i];
               expValid = 1'b1;
            end
            3'd7: sweepLeft = 32;
            default: ;
         endcase
      end
      #1;
      checkAll(tag);
   endtask

   // Called just after a compare point; reset pulse fits entirely between clock edges.
   task automatic resetPulse(input string tag);
      #1 reset = 1'b0;
      #1;
      sweepLeft = 32; expDout = 1'b0; expW = 8'h00; expValid = 1'b0; expErr = 1'b0;
      checkAll(tag);
      #1 reset = 1'b1;
   endtask

   initial begin
      logic [2:0] ro;
      en = 1'b0; op = 3'd0; addr = 8'h00; din = 1'b0; reset = 1'b0;
      for (int i = 0; i < 256; i++) refMem[i] = 1'bx;
      repeat (3) @(posedge clk);
      #1;
      sweepLeft = 32; expDout = 1'b0; expW = 8'h00; expValid = 1'b0; expErr = 1'b0;
      checkAll("rst");
      #1 reset = 1'b1;

      // Power-up sweep with requests on edge 5 and on the final edge.
      for (int e = 1; e <= 32; e++) begin
         step((e == 5) || (e == 32), 3'd1, 8'($urandom), 1'b0, "sweep");
         if (e == 5) check("err_edge5", 32'(err), 32'd1);
      end
      check("busy_after32", 32'(busy), 32'd0);
      for (int w = 0; w < 32; w++) begin
         step(1'b1, 3'd6, 8'(w * 8), 1'b0, "rdw_init");
         check("rdw_init_zero", 32'(wdout), 32'h00);
      end

      step(1'b1, 3'd2, 8'h13, 1'b1, "wr13");
      step(1'b1, 3'd1, 8'h13, 1'b0, "rd13");
      check("rd13_one", 32'(dout), 32'd1);
      step(1'b1, 3'd1, 8'h12, 1'b0, "rd12");
      check("rd12_zero", 32'(dout), 32'd0);

      step(1'b1, 3'd5, 8'h40, 1'b0, "tgl1"); check("tgl1_old", 32'(dout), 32'd0);
      step(1'b1, 3'd5, 8'h40, 1'b0, "tgl2"); check("tgl2_old", 32'(dout), 32'd1);
      step(1'b1, 3'd5, 8'h40, 1'b0, "tgl3"); check("tgl3_old", 32'(dout), 32'd0);
      step(1'b1, 3'd3, 8'h40, 1'b0, "set40"); check("set40_old", 32'(dout), 32'd1);
      step(1'b1, 3'd4, 8'h40, 1'b0, "clr40"); check("clr40_old", 32'(dout), 32'd1);
      step(1'b1, 3'd1, 8'h40, 1'b0, "rd40"); check("rd40_zero", 32'(dout), 32'd0);
      step(1'b0, 3'd1, 8'h40, 1'b0, "idle_hold");

      step(1'b1, 3'd2, 8'h21, 1'b1, "wr21");
      step(1'b1, 3'd2, 8'h23, 1'b1, "wr23");
      step(1'b1, 3'd2, 8'h27, 1'b1, "wr27");
      step(1'b1, 3'd6, 8'h25, 1'b0, "rdw25");
      check("rdw25_8A", 32'(wdout), 32'h8A);

      // Random traffic; CLRALL kept rare so most cycles exercise bit ops.
      for (int n = 0; n < 600; n++) begin
         ro = 3'($urandom_range(0, 7));
         if (ro == 3'd7 && $urandom_range(0, 9) != 0) ro = 3'd5;
         step($urandom_range(0, 3) != 0, ro, 8'($urandom_range(0, 31)), 1'($urandom), "rand");
      end
      while (sweepLeft > 0) step(1'b0, 3'd0, 8'h00, 1'b0, "drain");

      for (int n = 0; n < 20; n++) step(1'b1, 3'd2, 8'($urandom), 1'b1, "preset");
      step(1'b1, 3'd7, 8'h00, 1'b0, "clrall");
      check("clrall_busy", 32'(busy), 32'd1);
      for (int e = 1; e <= 10; e++) step(1'b0, 3'd0, 8'h00, 1'b0, "clrsweep");
      resetPulse("midrst");
      for (int e = 1; e <= 32; e++) step(1'b0, 3'd0, 8'h00, 1'b0, "resweep");
      check("busy_after_resweep", 32'(busy), 32'd0);
      for (int w = 0; w < 32; w++) begin
         step(1'b1, 3'd6, 8'(w * 8 + 3), 1'b0, "rdw_final");
         check("rdw_final_zero", 32'(wdout), 32'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end
endmodule

// File: doc/bit_ram_rmw.md
# bit_ram_rmw

Parametrised bit-addressable RAM for the IL processor's bit operand space, successor to the single-bit RAM. It adds configurable depth, atomic read-modify-write bit ops (set/clear/toggle, each returning the old bit), an aligned word read port, and a self-running clear sweep after reset and on command. It sits beside the byte RAM on the operand bus and is driven by the execute stage.

## Interface

- `DEPTH`, 256: number of bits stored; must be a power of two and a multiple of `WORD_W`.
- `ADDR_LEN`, 8: bit address width, log2(`DEPTH`).
- `WORD_W`, 8: word-port width; must be a power of two, 2..`DEPTH`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `en`  in  1  request strobe, sampled on the rising edge.
- `op`  in  3  operation code, see Operation.
- `addr`  in  `ADDR_LEN`  bit address; word ops use `addr[ADDR_LEN-1:log2(WORD_W)]`.
- `din`  in  1  write data for WR.
- `dout`  out  1  registered bit result.
- `wdout`  out  `WORD_W`  registered word result; bit i = mem[word_base + i].
- `valid`  out  1  one-cycle pulse: `dout`/`wdout` updated by the op accepted at this edge.
- `busy`  out  1  clear sweep in progress; requests are not accepted.
- `err`  out  1  one-cycle pulse: a request arrived while busy and was dropped.

## Operation

- Storage: `DEPTH` flops, not cleared by `reset`; cleared by the sweep.
- Accept: request accepted when `en`=1 and `busy`=0 at a rising edge. Otherwise no state change apart from `err`.
- Op codes:
  - 000 NOP: no effect, `valid`=0.
  - 001 RD: `dout` <= mem[addr], `valid`=1.
  - 010 WR: mem[addr] <= `din`, `valid`=0, `dout` held.
  - 011 SET: mem[addr] <= 1, `dout` <= old bit, `valid`=1.
  - 100 CLR: mem[addr] <= 0, `dout` <= old bit, `valid`=1.
  - 101 TGL: mem[addr] <= ~old, `dout` <= old bit, `valid`=1.
  - 110 RDW: `wdout` <= aligned word containing addr; low address bits ignored; `valid`=1.
  - 111 CLRALL: starts the sweep; `busy` <= 1; `valid`=0.
- RMW ops are atomic within one edge; no other op can intervene.
- Outputs never go to Z. `dout`/`wdout` hold their last value when no read-type op is accepted. A read-type op is RD, SET, CLR, TGL, or RDW.
- Sweep FSM states are IDLE and SWEEP, with a pointer `ptr` of width log2(`DEPTH`/`WORD_W`).
  - In SWEEP, each edge clears word[ptr] and increments `ptr`.
  - On the edge clearing the last word, the FSM returns to IDLE and `busy` <= 0.
- Reset: the FSM enters SWEEP with `ptr`=0, so every reset is followed by a full automatic clear.
- `err`: `err` <= 1 for one cycle on any edge where `en`=1 and `busy`=1. This includes `en` asserted on the same edge the sweep finishes, because `busy` is still 1 when sampled.

## Timing

- Reset values: `dout`=0, `wdout`=0, `valid`=0, `err`=0, `busy`=1, FSM=SWEEP, `ptr`=0.
- Sweep length is `DEPTH`/`WORD_W` edges; 32 edges at the defaults.
  - First edge after `reset` rises clears word 0.
  - `busy` falls after edge 32.
  - First request can be accepted at edge 33.
- CLRALL accepted at edge k: `busy`=1 after k, word 0 cleared at k+1, `busy`=0 after edge k+`DEPTH`/`WORD_W`.
- Op latency is 1. Results and `valid` are visible after the accepting edge. Memory updates are visible to an op accepted at the next edge, so back-to-back RMW on the same address needs no stall.
- `reset` asserted mid-sweep or mid-op: outputs go to reset values immediately. The sweep restarts from `ptr`=0. Any in-flight op is lost.
- `addr` ≥ `DEPTH` is impossible by width. Out-of-range parameter combinations are rejected at elaboration.

## Test plan

- Reset release with defaults -> `busy`=1 for exactly 32 edges. After that, RDW at addr 0x00, 0x08, …, 0xF8 each returns `wdout`=0x00.
- Request while busy: `en`=1, RD on edge 5 of the sweep -> `err` pulses once, `valid`=0, sweep still ends on edge 32.
- WR 1 to 0x13, then RD 0x13 -> `dout`=1 with `valid`=1. Then RD 0x12 -> `dout`=0.
- TGL 0x40 on three consecutive edges -> `dout`=0,1,0 and final mem[0x40]=1. Then SET 0x40 -> `dout`=1; then CLR 0x40 -> `dout`=1, after which RD returns 0.
- WR 1 to bits 0x21, 0x23, 0x27, then RDW with addr=0x25 -> `wdout`=0x8A, confirming the low address bits are ignored.
- With bits set, issue CLRALL and assert `reset` low at sweep edge 10 -> outputs return to reset values. On release there is a full 32-edge sweep, and all RDW reads return 0x00.
